// File: rtl/button_bank_debouncer_pkg.sv
// Shared types and default timing constants for the push-button front end (100 MHz clock).
package btn_pkg;

    localparam int DEBOUNCE_1MS = 32'd100_000;
    localparam int LONG_1S      = 32'd100_000_000;
    localparam int REPEAT_100MS = 32'd10_000_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HELD = ST_HELD,
        LONG = ST_LONG
    } hold_state_t;

    // Pin level that means "not pressed" for the given polarity.
    function automatic logic idle_pin_level(input int active_low);
        return (active_low != 32'sd0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/button_bank_debouncer_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and press/long hold FSM.
// With AUTO_REPEAT_EN defined, a held button in LONG re-emits press_evt every REPEAT_PERIOD cycles.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int ACTIVE_LOW      = 32'sd1,
    parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic clk_100mhz,
    input  logic reset,
    input  logic btn_pin,
    output logic btn_level,
    output logic press_evt,
    output logic release_evt,
    output logic long_evt
);

    localparam int  DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int  HW       = $clog2(LONG_CYCLES + 1);
    localparam logic IDLE_PIN = idle_pin_level(ACTIVE_LOW);

    if ((DEBOUNCE_CYCLES < 1) || (LONG_CYCLES < 2) || (REPEAT_PERIOD < 1)) begin : g_param_check
        $error("btn_channel: illegal timing parameters");
    end

    logic          sync1_r;
    logic          sync2_r;
    logic          pressed_s;
    logic [DW-1:0] db_cnt_r;
    logic          level_r;
    hold_state_t   state_r;
    logic [HW-1:0] hold_cnt_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_PERIOD + 1);
    logic [RW-1:0] rep_cnt_r;
`endif

    // Two-flop synchroniser, reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            sync1_r <= IDLE_PIN;
            sync2_r <= IDLE_PIN;
        end else begin
            sync1_r <= btn_pin;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = sync2_r ^ IDLE_PIN;

    // Debounce: a differing level must persist DEBOUNCE_CYCLES consecutive cycles to be accepted.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            db_cnt_r <= {DW{1'b0}};
            level_r  <= 1'b0;
        end else if (pressed_s == level_r) begin
            db_cnt_r <= {DW{1'b0}};
        end else if (db_cnt_r == DW'(DEBOUNCE_CYCLES - 1)) begin
            level_r  <= pressed_s;
            db_cnt_r <= {DW{1'b0}};
        end else begin
            db_cnt_r <= db_cnt_r + DW'(1);
        end
    end

    // Hold FSM; a release always takes priority over a long or repeat event in the same cycle.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            long_r     <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_r  <= {RW{1'b0}};
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (level_r) begin
                        press_r    <= 1'b1;
                        hold_cnt_r <= {HW{1'b0}};
                        state_r    <= HELD;
                    end
                end
                HELD: begin
                    if (!level_r) begin
                        release_r  <= 1'b1;
                        hold_cnt_r <= {HW{1'b0}};
                        state_r    <= IDLE;
                    end else if (hold_cnt_r == HW'(LONG_CYCLES - 1)) begin
                        long_r     <= 1'b1;
                        state_r    <= LONG;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_r  <= {RW{1'b0}};
`endif
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                LONG: begin
                    if (!level_r) begin
                        release_r  <= 1'b1;
                        hold_cnt_r <= {HW{1'b0}};
                        state_r    <= IDLE;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_r  <= {RW{1'b0}};
                    end else if (rep_cnt_r == RW'(REPEAT_PERIOD - 1)) begin
                        press_r    <= 1'b1;
                        rep_cnt_r  <= {RW{1'b0}};
                    end else begin
                        rep_cnt_r  <= rep_cnt_r + RW'(1);
`endif
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= {HW{1'b0}};
                end
            endcase
        end
    end

    assign btn_level   = level_r;
    assign press_evt   = press_r;
    assign release_evt = release_r;
    assign long_evt    = long_r;

endmodule

// File: rtl/button_bank_debouncer.sv
// N-channel push-button front end: one btn_channel per pin plus a combined any_evt flag.
// Optional feature macro: AUTO_REPEAT_EN (press_evt auto-repeat while a button is long-held).
module button_bank_debouncer
    import btn_pkg::*;
#(
    parameter int N_BTN           = 32'sd4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int ACTIVE_LOW      = 32'sd1,
    parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic             clk_100mhz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_evt,
    output logic [N_BTN-1:0] release_evt,
    output logic [N_BTN-1:0] long_evt,
    output logic             any_evt
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_100mhz  (clk_100mhz),
            .reset       (reset),
            .btn_pin     (btn_in[i]),
            .btn_level   (btn_level[i]),
            .press_evt   (press_evt[i]),
            .release_evt (release_evt[i]),
            .long_evt    (long_evt[i])
        );
    end

    // Event pulses are already registered, so this OR is aligned with them.
    assign any_evt = |(press_evt | release_evt | long_evt);

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Directed bench for button_bank_debouncer with short timing (D=4, L=20, R=5, N=4, active-low pins).
module tb_button_bank_debouncer;

    localparam int N = 4;

    logic         clk_100mhz;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_evt;
    logic [N-1:0] release_evt;
    logic [N-1:0] long_evt;
    logic         any_evt;

    int n_checks = 0;
    int n_errors = 0;
    int n_press   [N];
    int n_release [N];
    int n_long    [N];

    button_bank_debouncer #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .long_evt    (long_evt),
        .any_evt     (any_evt)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    // Per-channel pulse tallies, sampled mid-cycle.
    always @(negedge clk_100mhz) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                n_press[i]   += int'(press_evt[i]);
                n_release[i] += int'(release_evt[i]);
                n_long[i]    += int'(long_evt[i]);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    int seen_nonzero;
    int snap_a;
    int snap_b;
    int total;

    initial begin
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0;
            n_release[i] = 0;
            n_long[i] = 0;
        end
        reset  = 1'b1;
        btn_in = 4'hF;

        // 1: long reset, then idle
        seen_nonzero = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if ({btn_level, press_evt, release_evt, long_evt, any_evt} !== 17'd0) seen_nonzero = 1;
        end
        check_eq("reset_outputs_zero", 32'(seen_nonzero), 32'd0);
        reset = 1'b0;
        step(20);
        total = 0;
        for (int i = 0; i < N; i++) total += n_press[i] + n_release[i] + n_long[i];
        check_eq("post_reset_no_events", 32'(total), 32'd0);
        check_eq("post_reset_level", 32'(btn_level), 32'd0);

        // 2: ch0 glitch then steady press
        btn_in[0] = 1'b0;
        step(3);
        btn_in[0] = 1'b1;
        step(1);
        btn_in[0] = 1'b0;
        step(5);
        check_eq("glitch_no_level", 32'(btn_level), 32'd0);
        check_eq("glitch_no_press", 32'(n_press[0]), 32'd0);
        step(1);
        check_eq("ch0_level_at_6", 32'(btn_level), 32'h1);
        check_eq("ch0_press_not_yet", 32'(press_evt), 32'h0);
        step(1);
        check_eq("ch0_press_at_7", 32'(press_evt), 32'h1);
        check_eq("ch0_any_evt", 32'(any_evt), 32'h1);
        step(1);
        check_eq("ch0_press_single", 32'(press_evt), 32'h0);
        btn_in[0] = 1'b1;
        step(7);
        check_eq("ch0_release", 32'(release_evt), 32'h1);
        check_eq("ch0_level_low", 32'(btn_level), 32'h0);

        // 3: ch1 held 40 cycles
        snap_a = n_press[1];
        snap_b = n_long[1];
        btn_in[1] = 1'b0;
        step(7);
        check_eq("ch1_press", 32'(press_evt), 32'h2);
        step(19);
        check_eq("ch1_long_not_yet", 32'(long_evt), 32'h0);
        step(1);
        check_eq("ch1_long_at_20", 32'(long_evt), 32'h2);
        step(13);
        btn_in[1] = 1'b1;
        step(6);
        check_eq("ch1_level_dropped", 32'(btn_level), 32'h0);
        check_eq("ch1_release_not_yet", 32'(release_evt), 32'h0);
        step(1);
        check_eq("ch1_release", 32'(release_evt), 32'h2);
        step(2);
        check_eq("ch1_long_once", 32'(n_long[1] - snap_b), 32'd1);
`ifdef AUTO_REPEAT_EN
        check_eq("ch1_press_count", 32'(n_press[1] - snap_a), 32'd4);
`else
        check_eq("ch1_press_count", 32'(n_press[1] - snap_a), 32'd1);
`endif

        // 4: ch0 and ch2 pressed together
        btn_in = 4'b1010;
        step(6);
        check_eq("dual_any_before", 32'(any_evt), 32'h0);
        step(1);
        check_eq("dual_press", 32'(press_evt), 32'h5);
        check_eq("dual_any", 32'(any_evt), 32'h1);
        step(1);
        check_eq("dual_any_after", 32'(any_evt), 32'h0);
        btn_in = 4'hF;
        step(7);
        check_eq("dual_release", 32'(release_evt), 32'h5);

        // 5: reset while ch3 is in LONG
        btn_in[3] = 1'b0;
        step(27);
        check_eq("ch3_long", 32'(long_evt), 32'h8);
        step(2);
        reset = 1'b1;
        step(1);
        check_eq("midreset_outputs", 32'({btn_level, press_evt, release_evt, long_evt, any_evt}), 32'd0);
        reset = 1'b0;
        step(6);
        check_eq("ch3_relevel", 32'(btn_level), 32'h8);
        check_eq("ch3_repress_not_yet", 32'(press_evt), 32'h0);
        step(1);
        check_eq("ch3_repress", 32'(press_evt), 32'h8);
        step(19);
        check_eq("ch3_relong_not_yet", 32'(long_evt), 32'h0);
        step(1);
        check_eq("ch3_relong", 32'(long_evt), 32'h8);
        btn_in[3] = 1'b1;
        step(7);
        check_eq("ch3_release", 32'(release_evt), 32'h8);

        // 6: ch0 long hold, with or without auto-repeat
        step(3);
        btn_in[0] = 1'b0;
        step(27);
        check_eq("ch0_long", 32'(long_evt), 32'h1);
        snap_a = n_press[0];
`ifdef AUTO_REPEAT_EN
        for (int r = 0; r < 3; r++) begin
            step(4);
            check_eq("repeat_gap", 32'(press_evt), 32'h0);
            step(1);
            check_eq("repeat_pulse", 32'(press_evt), 32'h1);
        end
`else
        step(15);
        check_eq("no_repeat", 32'(n_press[0] - snap_a), 32'd0);
`endif
        snap_b = n_release[0];
        btn_in[0] = 1'b1;
        step(7);
        check_eq("ch0_long_release", 32'(release_evt), 32'h1);
        snap_a = n_press[0];
        step(10);
        check_eq("ch0_release_once", 32'(n_release[0] - snap_b), 32'd1);
        check_eq("ch0_no_press_after", 32'(n_press[0] - snap_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
